// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  // Fetch sequencer states: one memory request outstanding at most.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  // addi x0, x0, 0 -- substituted for fetches from a misaligned PC.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/if_inst_fifo.sv
// Synchronous instruction buffer between fetch and decode. Registered head,
// no write-through bypass; flush empties it on the next edge and drops any
// push presented in the same cycle.
module if_inst_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       ready,
  output logic                       valid,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~flush;
  assign do_pop  = valid & ready & ~flush;

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Entry storage; data only, never reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: takes the registered PC, issues one request at a
// time to instruction memory and queues {misalign, pc, inst} for decode.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pc_valid_i,
  output logic              pc_ready_o,
  output logic              stall_o,
  input  logic              flush_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_misalign_o,
  input  logic              inst_ready_i
);

  localparam int ENTRY_W = ADDR_W + DATA_W + 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  fetch_state_t        state;
  fetch_state_t        state_nxt;
  logic [ADDR_W-1:0]   pc_q;
  logic                kill_q;
  logic                accept;
  logic                misaligned;
  logic                push;
  logic [ENTRY_W-1:0]  push_data;
  logic [ENTRY_W-1:0]  head;
  logic                head_valid;
  logic [CNT_W-1:0]    fifo_count;

  // PC is only taken from IDLE, so the buffer count already covers every
  // result that can still arrive: a slot is effectively reserved at accept.
  assign pc_ready_o = rstn & (state == IDLE) & ~flush_i
                      & (fifo_count < CNT_W'(FIFO_DEPTH));
  assign stall_o    = ~pc_ready_o;
  assign accept     = pc_valid_i & pc_ready_o;
  assign misaligned = (pc_i[1:0] != 2'b00);

  assign imem_req_o  = (state == REQ);
  assign imem_addr_o = imem_req_o ? (pc_q & WORD_MASK) : '0;

  // Next-state and push selection for the fetch sequencer.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_data = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (misaligned) begin
            push      = 1'b1;
            push_data = {1'b1, pc_i, DATA_W'(NOP_INST)};
          end else begin
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        // A redirect seen while waiting for grant still completes the
        // handshake; the response is then discarded in DROP.
        if (imem_gnt_i) state_nxt = (flush_i | kill_q) ? DROP : WAIT;
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          state_nxt = IDLE;
          push      = ~flush_i;
          push_data = {1'b0, pc_q, imem_rdata_i};
        end else if (flush_i) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (imem_rvalid_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer state plus the sticky "redirected before grant" flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      kill_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      kill_q <= (state == REQ) && !imem_gnt_i && (kill_q || flush_i);
    end
  end

  // Fetch address capture; data only, outputs are gated so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) pc_q <= pc_i;
  end

  if_inst_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush_i),
    .push      (push),
    .push_data (push_data),
    .ready     (inst_ready_i),
    .valid     (head_valid),
    .head      (head),
    .count     (fifo_count)
  );

  assign inst_valid_o    = head_valid;
  assign inst_o          = head_valid ? head[DATA_W-1:0]      : '0;
  assign inst_pc_o       = head_valid ? head[DATA_W +: ADDR_W] : '0;
  assign inst_misalign_o = head_valid & head[ENTRY_W-1];

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed testbench for if_fetch_unit.
module tb_if_fetch_unit;

  logic        clk;
  logic        rstn;
  logic [31:0] pc_i;
  logic        pc_valid_i;
  logic        pc_ready_o;
  logic        stall_o;
  logic        flush_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_misalign_o;
  logic        inst_ready_i;

  int checks   = 0;
  int failures = 0;

  if_fetch_unit #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(2)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .pc_i            (pc_i),
    .pc_valid_i      (pc_valid_i),
    .pc_ready_o      (pc_ready_o),
    .stall_o         (stall_o),
    .flush_i         (flush_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_gnt_i      (imem_gnt_i),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .inst_valid_o    (inst_valid_o),
    .inst_o          (inst_o),
    .inst_pc_o       (inst_pc_o),
    .inst_misalign_o (inst_misalign_o),
    .inst_ready_i    (inst_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Advance to the next falling edge; inputs change and outputs are sampled there.
  task automatic nxt();
    @(negedge clk);
  endtask

  // Stimulus only: accept an aligned pc, grant at once, respond next cycle.
  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data);
    pc_i = pc; pc_valid_i = 1'b1;
    nxt();
    pc_valid_i = 1'b0; imem_gnt_i = 1'b1;
    nxt();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = data;
    nxt();
    imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; pc_valid_i = 1'b1; pc_i = 32'h40; imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'hdead_beef;
    nxt(); nxt(); #1;
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL rst_stall got=%b exp=1", stall_o); end
    checks++; if (pc_ready_o !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", pc_ready_o); end
    checks++; if ({imem_req_o, imem_addr_o} !== 33'h0) begin failures++; $display("FAIL rst_req got=%b/%h exp=0/0", imem_req_o, imem_addr_o); end
    checks++; if ({inst_valid_o, inst_misalign_o, inst_o, inst_pc_o} !== 66'h0) begin failures++; $display("FAIL rst_inst got=%b %b %h %h exp=0", inst_valid_o, inst_misalign_o, inst_o, inst_pc_o); end
    // Release reset with a stray response in IDLE: must not be queued.
    rstn = 1'b1; pc_valid_i = 1'b0;
    nxt();
    imem_rvalid_i = 1'b0; imem_rdata_i = '0; #1;
    checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL rst_stray_rvalid got=%b exp=0", inst_valid_o); end
    checks++; if (pc_ready_o !== 1'b1 || stall_o !== 1'b0) begin failures++; $display("FAIL rst_idle_ready got=%b/%b exp=1/0", pc_ready_o, stall_o); end
  endtask

  task automatic test_basic_fetch();
    inst_ready_i = 1'b0;
    pc_i = 32'h0; pc_valid_i = 1'b1; #1;
    checks++; if (pc_ready_o !== 1'b1) begin failures++; $display("FAIL t1_ready got=%b exp=1", pc_ready_o); end
    nxt();
    pc_valid_i = 1'b0; imem_gnt_i = 1'b1; #1;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin failures++; $display("FAIL t1_req got=%b/%h exp=1/00000000", imem_req_o, imem_addr_o); end
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL t1_stall_busy got=%b exp=1", stall_o); end
    nxt();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0050_0093; #1;
    checks++; if (imem_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin failures++; $display("FAIL t1_wait got=req%b/val%b exp=0/0", imem_req_o, inst_valid_o); end
    nxt();
    imem_rvalid_i = 1'b0; #1;
    checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0050_0093 || inst_pc_o !== 32'h0 || inst_misalign_o !== 1'b0)
      begin failures++; $display("FAIL t1_head got=%b %h %h %b exp=1 00500093 00000000 0", inst_valid_o, inst_o, inst_pc_o, inst_misalign_o); end
    inst_ready_i = 1'b1;
    nxt();
    inst_ready_i = 1'b0; #1;
    checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL t1_pop got=%b exp=0", inst_valid_o); end
  endtask

  task automatic test_backpressure();
    inst_ready_i = 1'b0;
    do_fetch(32'h00, 32'h1111_0001);
    do_fetch(32'h04, 32'h1111_0002);
    pc_i = 32'h08; pc_valid_i = 1'b1; #1;
    checks++; if (pc_ready_o !== 1'b0 || stall_o !== 1'b1) begin failures++; $display("FAIL t2_full got=%b/%b exp=0/1", pc_ready_o, stall_o); end
    nxt(); #1;
    checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL t2_no_req got=%b exp=0", imem_req_o); end
    checks++; if (inst_pc_o !== 32'h00 || inst_o !== 32'h1111_0001) begin failures++; $display("FAIL t2_head0 got=%h/%h exp=00000000/11110001", inst_pc_o, inst_o); end
    inst_ready_i = 1'b1; #1;
    checks++; if (pc_ready_o !== 1'b0) begin failures++; $display("FAIL t2_ready_on_pop got=%b exp=0", pc_ready_o); end
    nxt();
    inst_ready_i = 1'b0; #1;
    checks++; if (inst_pc_o !== 32'h04 || inst_o !== 32'h1111_0002) begin failures++; $display("FAIL t2_head1 got=%h/%h exp=00000004/11110002", inst_pc_o, inst_o); end
    checks++; if (pc_ready_o !== 1'b1) begin failures++; $display("FAIL t2_reopen got=%b exp=1", pc_ready_o); end
    nxt();
    pc_valid_i = 1'b0; imem_gnt_i = 1'b1; #1;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h08) begin failures++; $display("FAIL t2_req8 got=%b/%h exp=1/00000008", imem_req_o, imem_addr_o); end
    nxt();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h1111_0003;
    nxt();
    imem_rvalid_i = 1'b0; #1;
    checks++; if (inst_pc_o !== 32'h04) begin failures++; $display("FAIL t2_order got=%h exp=00000004", inst_pc_o); end
    inst_ready_i = 1'b1;
    nxt(); #1;
    checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h08 || inst_o !== 32'h1111_0003) begin failures++; $display("FAIL t2_head2 got=%b %h %h exp=1 00000008 11110003", inst_valid_o, inst_pc_o, inst_o); end
    nxt();
    inst_ready_i = 1'b0; #1;
    checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL t2_drained got=%b exp=0", inst_valid_o); end
  endtask

  task automatic test_flush_wait();
    inst_ready_i = 1'b0;
    do_fetch(32'h7c, 32'h2222_0000);
    pc_i = 32'h80; pc_valid_i = 1'b1;
    nxt();
    pc_valid_i = 1'b0; imem_gnt_i = 1'b1;
    nxt();
    imem_gnt_i = 1'b0; flush_i = 1'b1; #1;
    checks++; if (pc_ready_o !== 1'b0) begin failures++; $display("FAIL t3_flush_ready got=%b exp=0", pc_ready_o); end
    nxt();
    flush_i = 1'b0; #1;
    checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL t3_emptied got=%b exp=0", inst_valid_o); end
    checks++; if (pc_ready_o !== 1'b0 || imem_req_o !== 1'b0) begin failures++; $display("FAIL t3_drop got=rdy%b req%b exp=0/0", pc_ready_o, imem_req_o); end
    nxt();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hbad0_0080;
    nxt();
    imem_rvalid_i = 1'b0; #1;
    checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL t3_discard got=%b exp=0", inst_valid_o); end
    checks++; if (pc_ready_o !== 1'b1) begin failures++; $display("FAIL t3_idle got=%b exp=1", pc_ready_o); end
    do_fetch(32'h100, 32'h00a0_0113);
    checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h100 || inst_o !== 32'h00a0_0113) begin failures++; $display("FAIL t3_refetch got=%b %h %h exp=1 00000100 00a00113", inst_valid_o, inst_pc_o, inst_o); end
    inst_ready_i = 1'b1;
    nxt();
    inst_ready_i = 1'b0; #1;
  endtask

  task automatic test_flush_req();
    int reqs;
    pc_i = 32'h400; pc_valid_i = 1'b1;
    nxt();
    pc_valid_i = 1'b0; flush_i = 1'b1; #1;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h400) begin failures++; $display("FAIL t7_req_flush got=%b/%h exp=1/00000400", imem_req_o, imem_addr_o); end
    nxt();
    flush_i = 1'b0; #1;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h400) begin failures++; $display("FAIL t7_req_held got=%b/%h exp=1/00000400", imem_req_o, imem_addr_o); end
    imem_gnt_i = 1'b1;
    nxt();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hbad0_0400;
    nxt();
    imem_rvalid_i = 1'b0; #1;
    reqs = 0;
    checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL t7_dropped got=%b exp=0", inst_valid_o); end
    checks++; if (pc_ready_o !== 1'b1) begin failures++; $display("FAIL t7_idle got=%b exp=1", pc_ready_o); end
  endtask

  task automatic test_gnt_delay();
    int reqs;
    reqs = 0;
    inst_ready_i = 1'b0;
    pc_i = 32'h200; pc_valid_i = 1'b1;
    nxt();
    pc_valid_i = 1'b0; pc_i = 32'hffff_fff0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin failures++; $display("FAIL t4_hold%0d got=%b/%h exp=1/00000200", i, imem_req_o, imem_addr_o); end
      nxt();
    end
    imem_gnt_i = 1'b1; #1;
    if (imem_req_o === 1'b1) reqs++;
    nxt();
    imem_gnt_i = 1'b0; #1;
    if (imem_req_o === 1'b1) reqs++;
    checks++; if (reqs !== 1) begin failures++; $display("FAIL t4_one_req got=%0d exp=1", reqs); end
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h3333_0200;
    nxt();
    imem_rvalid_i = 1'b0; #1;
    checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h200 || inst_o !== 32'h3333_0200) begin failures++; $display("FAIL t4_deliver got=%b %h %h exp=1 00000200 33330200", inst_valid_o, inst_pc_o, inst_o); end
    inst_ready_i = 1'b1;
    nxt();
    inst_ready_i = 1'b0; #1;
  endtask

  task automatic test_misalign();
    pc_i = 32'h0000_0082; pc_valid_i = 1'b1; #1;
    checks++; if (pc_ready_o !== 1'b1) begin failures++; $display("FAIL t5_ready got=%b exp=1", pc_ready_o); end
    nxt();
    pc_valid_i = 1'b0; #1;
    checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL t5_no_req got=%b exp=0", imem_req_o); end
    checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0000_0013 || inst_pc_o !== 32'h82 || inst_misalign_o !== 1'b1)
      begin failures++; $display("FAIL t5_nop got=%b %h %h %b exp=1 00000013 00000082 1", inst_valid_o, inst_o, inst_pc_o, inst_misalign_o); end
    inst_ready_i = 1'b1;
    nxt();
    inst_ready_i = 1'b0; #1;
    checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL t5_pop got=%b exp=0", inst_valid_o); end
  endtask

  task automatic test_reset_in_wait();
    pc_i = 32'h300; pc_valid_i = 1'b1;
    nxt();
    pc_valid_i = 1'b0; imem_gnt_i = 1'b1;
    nxt();
    imem_gnt_i = 1'b0; rstn = 1'b0; #1;
    checks++; if (stall_o !== 1'b1 || pc_ready_o !== 1'b0) begin failures++; $display("FAIL t6_stall got=%b/%b exp=1/0", stall_o, pc_ready_o); end
    nxt();
    rstn = 1'b1; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hbad0_0300; #1;
    checks++; if (imem_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin failures++; $display("FAIL t6_after_rst got=req%b val%b exp=0/0", imem_req_o, inst_valid_o); end
    nxt();
    imem_rvalid_i = 1'b0; #1;
    checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL t6_no_push got=%b exp=0", inst_valid_o); end
    checks++; if (pc_ready_o !== 1'b1) begin failures++; $display("FAIL t6_idle got=%b exp=1", pc_ready_o); end
  endtask

  task automatic test_back_to_back();
    inst_ready_i = 1'b1;
    do_fetch(32'h500, 32'h4444_0500);
    checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h500 || inst_o !== 32'h4444_0500) begin failures++; $display("FAIL t8_first got=%b %h %h exp=1 00000500 44440500", inst_valid_o, inst_pc_o, inst_o); end
    pc_i = 32'h504; pc_valid_i = 1'b1;
    nxt();
    pc_valid_i = 1'b0; #1;
    checks++; if (inst_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h504) begin failures++; $display("FAIL t8_overlap got=val%b req%b %h exp=0 1 00000504", inst_valid_o, imem_req_o, imem_addr_o); end
    imem_gnt_i = 1'b1;
    nxt();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h4444_0504;
    nxt();
    imem_rvalid_i = 1'b0; #1;
    checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h504) begin failures++; $display("FAIL t8_second got=%b %h exp=1 00000504", inst_valid_o, inst_pc_o); end
    nxt();
    inst_ready_i = 1'b0; #1;
  endtask

  initial begin
    rstn = 1'b0; pc_i = '0; pc_valid_i = 1'b0; flush_i = 1'b0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0; inst_ready_i = 1'b0;
    nxt();
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_flush_wait();
    test_flush_req();
    test_gnt_delay();
    test_misalign();
    test_reset_in_wait();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
